// File: rtl/mux_nx1_scan_if.sv
// Channel bus for mux_nx1_scan: N_CH inputs, select/mode/enable controls, one registered output.
// MUX_CH_MASK_EN adds the per-channel enable mask ch_mask.
interface mux_nx1_scan_if #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 1
);
  localparam int unsigned SEL_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*WIDTH-1:0] in;
  logic [SEL_W-1:0]      sel;
  logic                  mode;
  logic                  en;
`ifdef MUX_CH_MASK_EN
  logic [N_CH-1:0]       ch_mask;
`endif
  logic [WIDTH-1:0]      out;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  sel_err;
  logic                  scan_wrap;

`ifdef MUX_CH_MASK_EN
  modport master (output in, sel, mode, en, ch_mask,
                  input  out, out_ch, out_valid, sel_err, scan_wrap);
  modport slave  (input  in, sel, mode, en, ch_mask,
                  output out, out_ch, out_valid, sel_err, scan_wrap);
`else
  modport master (output in, sel, mode, en,
                  input  out, out_ch, out_valid, sel_err, scan_wrap);
  modport slave  (input  in, sel, mode, en,
                  output out, out_ch, out_valid, sel_err, scan_wrap);
`endif
endinterface

// File: rtl/mux_nx1_scan.sv
// Registered N_CH:1 mux with manual select and auto-scan (programmable dwell, wrap pulse).
// Optional MUX_CH_MASK_EN: ch_mask skips disabled channels in scan and rejects them in manual.
module mux_nx1_scan #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DWELL = 4
) (
  input logic            clk,
  input logic            rst_n,
  mux_nx1_scan_if.slave  bus
);
  localparam int unsigned SEL_W = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d, ptr_next, ptr_first;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;
  logic [N_CH-1:0]    mask;
  logic               dwell_last;
  logic               ptr_wraps;

`ifdef MUX_CH_MASK_EN
  assign mask = bus.ch_mask;
`else
  assign mask = '1;
`endif

  function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] data,
                                            input logic [SEL_W-1:0]      idx);
    pick = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (i == 32'(idx)) pick = data[i*WIDTH +: WIDTH];
  endfunction

  // Out-of-range indices read as disabled
  function automatic logic chan_on(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] idx);
    chan_on = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++)
      if (i == 32'(idx)) chan_on = m[i];
  endfunction

  // Nearest enabled index after p, circularly; p itself if it is the only one
  function automatic logic [SEL_W-1:0] next_on(input logic [N_CH-1:0] m, input logic [SEL_W-1:0] p);
    int idx;
    next_on = p;
    for (int k = int'(N_CH); k >= 1; k--) begin
      idx = int'(p) + k;
      if (idx >= int'(N_CH)) idx = idx - int'(N_CH);
      if (m[idx]) next_on = SEL_W'(idx);
    end
  endfunction

  function automatic logic [SEL_W-1:0] first_on(input logic [N_CH-1:0] m);
    first_on = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--)
      if (m[i]) first_on = SEL_W'(i);
  endfunction

  always_comb begin
    ptr_next   = next_on(mask, ptr_q);
    ptr_first  = first_on(mask);
    ptr_wraps  = (ptr_next <= ptr_q);
    dwell_last = (int'(cnt_q) == int'(DWELL) - 1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: en gates everything, mode picks the active state
  always_comb begin
    state_d = state_q;
    if (!bus.en)       state_d = IDLE;
    else if (bus.mode) state_d = SCAN;
    else               state_d = MANUAL;
  end

  // Output/datapath next values, driven by the state held during this cycle
  always_comb begin
    out_d    = out_q;
    out_ch_d = out_ch_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    if (bus.en) begin
      case (state_q)
        MANUAL: begin
          if (chan_on(mask, bus.sel)) begin
            out_d    = pick(bus.in, bus.sel);
            out_ch_d = bus.sel;
            valid_d  = 1'b1;
          end else begin
            out_d    = '0;
            out_ch_d = '0;
            err_d    = 1'b1;
          end
        end
        SCAN: begin
          if (|mask) begin
            out_d    = pick(bus.in, ptr_q);
            out_ch_d = ptr_q;
            valid_d  = 1'b1;
            if (dwell_last) begin
              cnt_d  = '0;
              ptr_d  = ptr_next;
              wrap_d = ptr_wraps;
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    if (state_d == SCAN && state_q != SCAN) begin
      ptr_d = ptr_first;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;
  assign bus.scan_wrap = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: vector table, directed corner sequences and a random run against a reference model.
module tb_mux_nx1_scan;
  localparam int N = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_nb;

  mux_nx1_scan_if #(.N_CH(N), .WIDTH(1)) bus_a ();
  mux_nx1_scan #(.N_CH(N), .WIDTH(1), .DWELL(D)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  mux_nx1_scan_if #(.N_CH(5), .WIDTH(1)) bus_b ();
  mux_nx1_scan #(.N_CH(5), .WIDTH(1), .DWELL(D)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(bus_b));

`ifdef MUX_CH_MASK_EN
  mux_nx1_scan_if #(.N_CH(N), .WIDTH(1)) bus_c ();
  mux_nx1_scan #(.N_CH(N), .WIDTH(1), .DWELL(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 manual, 2 scan; m_k counts valid scan cycles since entry
  int   m_st = 0;
  int   m_k  = 0;
  logic m_out = 1'b0;
  int   m_ch = 0;
  logic m_valid = 1'b0, m_err = 1'b0, m_wrap = 1'b0;

  typedef struct {
    logic [7:0] in;
    logic [2:0] sel;
    logic       exp_out;
    logic [2:0] exp_ch;
    logic       exp_valid;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nst;
    int ch;
    if (!rst_n) begin
      m_out = 1'b0; m_ch = 0; m_valid = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
      m_st = 0; m_k = 0;
    end else begin
      m_valid = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
      if (bus_a.en) begin
        if (m_st == 1) begin
          if (int'(bus_a.sel) < N) begin
            m_out = bus_a.in[bus_a.sel]; m_ch = int'(bus_a.sel); m_valid = 1'b1;
          end else begin
            m_out = 1'b0; m_ch = 0; m_err = 1'b1;
          end
        end else if (m_st == 2) begin
          ch      = (m_k / D) % N;
          m_out   = bus_a.in[ch];
          m_ch    = ch;
          m_valid = 1'b1;
          m_wrap  = ((m_k % (N * D)) == N * D - 1);
          m_k++;
        end
      end
      nst = !bus_a.en ? 0 : (bus_a.mode ? 2 : 1);
      if (nst == 2 && m_st != 2) m_k = 0;
      m_st = nst;
    end
  endtask

  // One clock: model follows the sampled inputs, outputs compared just after the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out",       32'(bus_a.out),       32'(m_out));
    chk("out_ch",    32'(bus_a.out_ch),    32'(m_ch));
    chk("out_valid", 32'(bus_a.out_valid), 32'(m_valid));
    chk("sel_err",   32'(bus_a.sel_err),   32'(m_err));
    chk("scan_wrap", 32'(bus_a.scan_wrap), 32'(m_wrap));
  endtask

  task automatic wait_ch(input int ch, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (int'(bus_a.out_ch) == ch && bus_a.out_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_out_ch", 32'(found), 32'd1);
  endtask

  initial begin
    logic [7:0] a5;
    logic       held;
    a5 = 8'hA5;

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{8'(1 << i),  3'(i), 1'b1, 3'(i), 1'b1};
      tbl[8 + i] = '{~8'(1 << i), 3'(i), 1'b0, 3'(i), 1'b1};
    end

    rst_n = 1'b0; rst_nb = 1'b0;
    bus_a.in = 8'hFF; bus_a.sel = '0; bus_a.mode = 1'b1; bus_a.en = 1'b1;
    bus_b.in = '0; bus_b.sel = '0; bus_b.mode = 1'b0; bus_b.en = 1'b0;
`ifdef MUX_CH_MASK_EN
    bus_a.ch_mask = '1;
    bus_b.ch_mask = '1;
    bus_c.in = 8'hFF; bus_c.sel = '0; bus_c.mode = 1'b1; bus_c.en = 1'b0; bus_c.ch_mask = '1;
`endif

    // Reset dominates en/mode
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out", 32'(bus_a.out), 32'd0);
      chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
    end

    // Manual walking one / walking zero
    rst_n = 1'b1; bus_a.mode = 1'b0;
    step();
    chk("startup_valid", 32'(bus_a.out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus_a.in = tbl[i].in; bus_a.sel = tbl[i].sel;
      step();
      chk("tbl_out",   32'(bus_a.out),       32'(tbl[i].exp_out));
      chk("tbl_ch",    32'(bus_a.out_ch),    32'(tbl[i].exp_ch));
      chk("tbl_valid", 32'(bus_a.out_valid), 32'(tbl[i].exp_valid));
    end

    // Two full sweeps of 0xA5
    bus_a.in = a5; bus_a.mode = 1'b1;
    step();
    for (int k = 0; k < 2 * N * D; k++) begin
      step();
      chk("scan_ch",   32'(bus_a.out_ch),    32'((k / D) % N));
      chk("scan_out",  32'(bus_a.out),       32'(a5[(k / D) % N]));
      chk("scan_wrap_seq", 32'(bus_a.scan_wrap), 32'(k == 31 || k == 63));
    end

    // Reset mid-scan, restart from channel 0
    wait_ch(3, 40);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("midrst_ch", 32'(bus_a.out_ch), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("restart_ch", 32'(bus_a.out_ch), 32'd0);
    chk("restart_valid", 32'(bus_a.out_valid), 32'd1);

    // Scan -> manual takes two edges; en=0 drops valid and holds data
    wait_ch(4, 40);
    bus_a.mode = 1'b0; bus_a.sel = 3'd5; bus_a.in = 8'h20;
    step();
    step();
    chk("switch_ch", 32'(bus_a.out_ch), 32'd5);
    chk("switch_out", 32'(bus_a.out), 32'd1);
    held = bus_a.out;
    bus_a.en = 1'b0; bus_a.in = 8'h00;
    step();
    chk("dis_valid", 32'(bus_a.out_valid), 32'd0);
    chk("dis_hold", 32'(bus_a.out), 32'(held));
    chk("dis_ch", 32'(bus_a.out_ch), 32'd5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      bus_a.en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) bus_a.mode = ~bus_a.mode;
      bus_a.sel = 3'($urandom);
      bus_a.in  = 8'($urandom);
      step();
    end
    rst_n = 1'b1; bus_a.en = 1'b0;

    // Range error on a 5-channel instance
    rst_nb = 1'b1; bus_b.en = 1'b1; bus_b.mode = 1'b0; bus_b.sel = 3'd6; bus_b.in = 5'b11111;
    step();
    step();
    chk("range_err",   32'(bus_b.sel_err),   32'd1);
    chk("range_valid", 32'(bus_b.out_valid), 32'd0);
    chk("range_out",   32'(bus_b.out),       32'd0);
    bus_b.sel = 3'd2; bus_b.in = 5'b00100;
    step();
    chk("inrange_err",   32'(bus_b.sel_err),   32'd0);
    chk("inrange_valid", 32'(bus_b.out_valid), 32'd1);
    chk("inrange_ch",    32'(bus_b.out_ch),    32'd2);
    chk("inrange_out",   32'(bus_b.out),       32'd1);
    bus_b.sel = 3'd4; bus_b.in = 5'b01111;
    step();
    chk("edge_ch",  32'(bus_b.out_ch), 32'd4);
    chk("edge_out", 32'(bus_b.out),    32'd0);

`ifdef MUX_CH_MASK_EN
    begin
      int exp_seq[6];
      exp_seq = '{0, 2, 7, 0, 2, 7};
      bus_c.ch_mask = 8'b1000_0101; bus_c.en = 1'b1; bus_c.mode = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
        step();
        chk("mask_ch",   32'(bus_c.out_ch),    32'(exp_seq[i]));
        chk("mask_wrap", 32'(bus_c.scan_wrap), 32'(exp_seq[i] == 7));
      end
      bus_c.ch_mask = '0;
      step();
      chk("mask_zero_valid", 32'(bus_c.out_valid), 32'd0);
      bus_c.ch_mask = 8'b1000_0101; bus_c.mode = 1'b0; bus_c.sel = 3'd1;
      step();
      step();
      chk("mask_sel_err",   32'(bus_c.sel_err),   32'd1);
      chk("mask_sel_valid", 32'(bus_c.out_valid), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N-channel to 1 multiplexer.
- Generalises the fixed 8x1 combinational mux to configurable channel count and data width.
- Two modes: manual select (external sel) and auto-scan (internal pointer with programmable dwell), plus a wrap indication.
- Sits in front of a single-channel consumer (monitor/serialiser) that samples channels one at a time.

Parameters:
- N_CH, 8, number of input channels (2..64; need not be a power of 2).
- WIDTH, 1, bits per channel.
- DWELL, 4, consecutive valid cycles each channel is presented in scan mode (>=1).
- SEL_W, derived localparam = max(1, clog2(N_CH)), select/index width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset; synchronous and active-low; priority over all other inputs.
- in  in  N_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = scan.
- en  in  1  block enable.
- out  out  WIDTH  registered selected channel data.
- out_ch  out  SEL_W  index of the channel currently on out.
- out_valid  out  1  out/out_ch hold a valid sample this cycle.
- sel_err  out  1  manual sel >= N_CH.
- scan_wrap  out  1  one-cycle pulse at end of a full sweep.

Behaviour:
- Reset (rst_n=0 at an edge): out=0, out_ch=0, out_valid=0, sel_err=0, scan_wrap=0. Scan pointer=0, dwell counter=0, state=IDLE.
- FSM states: IDLE, MANUAL, SCAN.
  - Any state -> IDLE when en=0.
  - IDLE -> MANUAL when en=1 and mode=0; IDLE -> SCAN when en=1 and mode=1.
  - MANUAL <-> SCAN follows mode while en=1.
  - Every entry into SCAN clears the pointer and dwell counter to 0.
- Startup latency: the edge that samples en=1 changes state. The first valid output appears on the following edge.
- IDLE: out_valid=0, sel_err=0, scan_wrap=0; out and out_ch hold their last values.
- MANUAL, steady state: 1-cycle latency. At each edge:
  - sel < N_CH: out<=in[sel], out_ch<=sel, out_valid<=1, sel_err<=0.
  - sel >= N_CH: out<=0, out_ch<=0, out_valid<=0, sel_err<=1.
  - scan_wrap=0.
- SCAN, at each edge:
  - out<=in[p], out_ch<=p, out_valid<=1, sel_err<=0; sel is ignored.
  - Dwell counter increments each cycle. At DWELL-1 it clears to 0 and p advances (N_CH-1 wraps to 0).
  - Each channel is therefore presented for exactly DWELL consecutive valid cycles.
  - scan_wrap=1 only on the last valid cycle of channel N_CH-1, then 0.
- Data is not latched: each valid cycle reflects the current in[p] sampled at that edge.
- mode toggle mid-scan to manual: the next edge enters MANUAL; the following edge presents sel. The scan position is discarded.
- Reset mid-operation: the next edge forces reset values regardless of en/mode. After release, entry into SCAN restarts at channel 0.

Optional Feature:
- Macro: MUX_CH_MASK_EN.
- Defined: adds port ch_mask (in, N_CH), 1 = channel enabled.
  - SCAN advances to the next enabled index modulo N_CH, skipping masked channels.
  - scan_wrap pulses on the last valid cycle before the pointer moves to a lower index.
  - SCAN entry starts at the lowest enabled index.
  - All-zero mask: out_valid=0, pointer and counter hold.
  - MANUAL with sel on a masked channel: out=0, out_valid=0, sel_err=1.
- Undefined: no ch_mask port; all channels enabled; behaviour as above.

Test Plan:
- Reset: rst_n=0 for 3 cycles, en=1, mode=1, in=8'hFF -> out=0, out_ch=0, out_valid=0, sel_err=0, scan_wrap=0 throughout.
- Manual walking-one (N_CH=8, WIDTH=1): in=1<<i, sel=i for i=0..7 -> out=1, out_ch=i, out_valid=1 one cycle later. Then in=~(1<<i), same sel -> out=0.
- Scan (DWELL=4, in=8'hA5): out_ch runs 0x4, 1x4, ..., 7x4 with out = 1,0,1,0,0,1,0,1 per channel. scan_wrap high only on valid cycle 32, then the sequence repeats from 0.
- Range error (N_CH=5, SEL_W=3): sel=6 -> sel_err=1, out_valid=0, out=0. Then sel=2 -> sel_err=0, out_valid=1, out_ch=2 next cycle.
- Mid-operation: rst_n=0 while out_ch=3 in scan -> outputs reset on that edge. Release with en=1, mode=1 -> first valid out_ch=0.
- Mode switch: scan at out_ch=4, then mode=0, sel=5 -> out_ch=5 two edges later. en=0 -> out_valid=0 next edge, out held.
- Mask (MUX_CH_MASK_EN, N_CH=8, DWELL=1): ch_mask=8'b1000_0101 -> out_ch 0,2,7,0,2,7 with scan_wrap on each 7. ch_mask=0 -> out_valid=0.
